// File: rtl/cpu_branch_predictor_pkg.sv
// Shared definitions for the branch predictor: direction-counter encodings,
// the initial counter values used on allocation, and the update classification.
package cpu_branch_predictor_pkg;

    // 2-bit saturating direction counter states; predict taken iff bit 1 is set.
    localparam logic [1:0] BP_CTR_SNT = 2'd0;
    localparam logic [1:0] BP_CTR_WNT = 2'd1;
    localparam logic [1:0] BP_CTR_WT  = 2'd2;
    localparam logic [1:0] BP_CTR_ST  = 2'd3;

    // Counter value written when a new entry is allocated.
    localparam logic [1:0] BP_CTR_INIT_BRANCH = BP_CTR_WT;
    localparam logic [1:0] BP_CTR_INIT_JUMP   = BP_CTR_ST;

    typedef enum logic [1:0] {
        UPD_NONE   = 2'd0,
        UPD_JUMP   = 2'd1,
        UPD_BRANCH = 2'd2
    } upd_kind_e;

    // A jump flag takes priority if both type flags are ever raised together.
    function automatic upd_kind_e classify_update(input logic valid,
                                                  input logic is_jump,
                                                  input logic is_branch);
        if (!valid)
            return UPD_NONE;
        else if (is_jump)
            return UPD_JUMP;
        else if (is_branch)
            return UPD_BRANCH;
        else
            return UPD_NONE;
    endfunction

endpackage

// File: rtl/cpu_sat_counter2.sv
// Combinational next-state for a 2-bit saturating up/down counter.
// Ports:
//   ctr      in   current counter value
//   inc      in   1 = count up (taken), 0 = count down (not taken)
//   ctr_next out  counter after one step, clamped to [SNT, ST]
module cpu_sat_counter2
    import cpu_branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       inc,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (inc && (ctr != BP_CTR_ST))
            ctr_next = ctr + 2'd1;
        else if (!inc && (ctr != BP_CTR_SNT))
            ctr_next = ctr - 2'd1;
    end

endmodule

// File: rtl/cpu_branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Fetch looks up a PC combinationally; the resolution stage trains the table
// on the rising edge.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   flush                            invalidate every entry at the next edge
//   lookup_pc                        fetch PC
//   lookup_hit/is_jump/taken/target  prediction for lookup_pc
//   upd_valid/pc/is_jump/is_branch/taken/target  resolved control-flow outcome
module cpu_branch_predictor
    import cpu_branch_predictor_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_hit,
    output logic            lookup_is_jump,
    output logic            lookup_taken,
    output logic [XLEN-1:0] lookup_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_is_jump,
    input  logic            upd_is_branch,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    // Storage: only the valid vector is reset; payload arrays are qualified by it.
    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] valid_d;
    logic [ENTRIES-1:0] is_jump_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    // PC bits [1:0] never take part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    // ---------------- Lookup (zero latency, reads pre-update contents) ----------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[XLEN-1:IDX_W+2];

    assign lookup_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lookup_is_jump = lookup_hit && is_jump_q[lk_idx];
    assign lookup_taken   = lookup_hit && (is_jump_q[lk_idx] || ctr_q[lk_idx][1]);
    assign lookup_target  = target_q[lk_idx];

    // ---------------- Update decode ---------------------------------------------
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    upd_kind_e        up_kind;
    logic [1:0]       ctr_stepped;

    assign up_idx  = upd_pc[IDX_W+1:2];
    assign up_tag  = upd_pc[XLEN-1:IDX_W+2];
    assign up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign up_kind = classify_update(upd_valid, upd_is_jump, upd_is_branch);

    cpu_sat_counter2 u_sat_counter (
        .ctr      (ctr_q[up_idx]),
        .inc      (upd_taken),
        .ctr_next (ctr_stepped)
    );

    logic       wr_en;
    logic       wr_target_en;
    logic       wr_is_jump;
    logic [1:0] wr_ctr;

    always_comb begin
        wr_en        = 1'b0;
        wr_target_en = 1'b0;
        wr_is_jump   = 1'b0;
        wr_ctr       = ctr_stepped;
        case (up_kind)
            UPD_JUMP: begin
                wr_en        = 1'b1;
                wr_target_en = 1'b1;
                wr_is_jump   = 1'b1;
                wr_ctr       = BP_CTR_INIT_JUMP;
            end
            UPD_BRANCH: begin
                if (up_hit) begin
                    // Train in place; the target only moves when the branch was taken.
                    wr_en        = 1'b1;
                    wr_target_en = upd_taken;
                end else if (upd_taken) begin
                    // Allocate over whatever lives in this slot.
                    wr_en        = 1'b1;
                    wr_target_en = 1'b1;
                    wr_ctr       = BP_CTR_INIT_BRANCH;
                end
            end
            default: ;
        endcase
    end

    // Flush overrides any same-cycle update.
    logic commit;
    assign commit = wr_en && !flush;

    // ---------------- Valid vector -----------------------------------------------
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_valid
            assign valid_d[gi] = !flush &&
                                 (valid_q[gi] || (commit && (up_idx == IDX_W'(gi))));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid_q <= '0;
        else
            valid_q <= valid_d;
    end

    // ---------------- Payload arrays (no reset) ---------------------------------
    always_ff @(posedge clk) begin
        if (commit) begin
            tag_q[up_idx]     <= up_tag;
            ctr_q[up_idx]     <= wr_ctr;
            is_jump_q[up_idx] <= wr_is_jump;
            if (wr_target_en)
                target_q[up_idx] <= upd_target;
        end
    end

endmodule

// File: tb/tb_cpu_branch_predictor.sv
module tb_cpu_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] lookup_pc;
    logic        lookup_hit;
    logic        lookup_is_jump;
    logic        lookup_taken;
    logic [31:0] lookup_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_jump;
    logic        upd_is_branch;
    logic        upd_taken;
    logic [31:0] upd_target;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cpu_branch_predictor #(.XLEN(32), .ENTRIES(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .lookup_pc      (lookup_pc),
        .lookup_hit     (lookup_hit),
        .lookup_is_jump (lookup_is_jump),
        .lookup_taken   (lookup_taken),
        .lookup_target  (lookup_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_is_jump    (upd_is_jump),
        .upd_is_branch  (upd_is_branch),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        upd_valid     = 1'b0;
        upd_is_jump   = 1'b0;
        upd_is_branch = 1'b0;
        upd_taken     = 1'b0;
        flush         = 1'b0;
    endtask

    // ---------------- Directed vector table ----------------
    typedef struct {
        logic        uv, uj, ub, ut;
        logic [31:0] upc, utgt;
        logic        fl;
        logic [31:0] lpc;
        logic        e_hit, e_jmp, e_tkn, chk_tgt;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic uv, logic uj, logic ub, logic ut,
                                logic [31:0] upc, logic [31:0] utgt, logic fl,
                                logic [31:0] lpc, logic eh, logic ej, logic et,
                                logic ct, logic [31:0] etg);
        vec_t v;
        v.uv = uv; v.uj = uj; v.ub = ub; v.ut = ut;
        v.upc = upc; v.utgt = utgt; v.fl = fl; v.lpc = lpc;
        v.e_hit = eh; v.e_jmp = ej; v.e_tkn = et; v.chk_tgt = ct; v.e_tgt = etg;
        return v;
    endfunction

    task automatic apply_vec(input int n, input vec_t v);
        if (v.uv || v.fl) begin
            upd_valid = v.uv; upd_is_jump = v.uj; upd_is_branch = v.ub;
            upd_taken = v.ut; upd_pc = v.upc; upd_target = v.utgt; flush = v.fl;
            @(posedge clk);
            #1;
            idle_inputs();
        end
        lookup_pc = v.lpc;
        #1;
        $display("vec %0d: upd(v=%0b j=%0b b=%0b t=%0b pc=%0h) flush=%0b lookup %0h -> hit=%0b jmp=%0b tkn=%0b tgt=%0h",
                 n, v.uv, v.uj, v.ub, v.ut, v.upc, v.fl, v.lpc,
                 lookup_hit, lookup_is_jump, lookup_taken, lookup_target);
        chk($sformatf("vec%0d hit", n), 32'(lookup_hit), 32'(v.e_hit));
        chk($sformatf("vec%0d is_jump", n), 32'(lookup_is_jump), 32'(v.e_jmp));
        chk($sformatf("vec%0d taken", n), 32'(lookup_taken), 32'(v.e_tkn));
        if (v.chk_tgt)
            chk($sformatf("vec%0d target", n), lookup_target, v.e_tgt);
    endtask

    // ---------------- Behavioural reference model ----------------
    // Table of entries keyed by slot number; direction counter is a plain int in 0..3.
    bit          m_valid [16];
    int unsigned m_tag   [16];
    bit          m_jump  [16];
    int          m_ctr   [16];
    logic [31:0] m_tgt   [16];

    function automatic int slot_of(logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic int unsigned tag_of(logic [31:0] pc);
        return pc / 64;
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_valid[slot_of(pc)] && (m_tag[slot_of(pc)] == tag_of(pc));
    endfunction

    task automatic model_update(input bit fl, input bit uv, input bit uj, input bit ub,
                                input bit ut, input logic [31:0] pc, input logic [31:0] tgt);
        int s;
        s = slot_of(pc);
        if (fl) begin
            foreach (m_valid[i]) m_valid[i] = 0;
        end else if (uv && uj) begin
            m_valid[s] = 1; m_tag[s] = tag_of(pc); m_jump[s] = 1; m_ctr[s] = 3; m_tgt[s] = tgt;
        end else if (uv && ub) begin
            if (m_hit(pc)) begin
                m_ctr[s] = ut ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3)
                              : ((m_ctr[s] > 0) ? m_ctr[s] - 1 : 0);
                m_jump[s] = 0;
                if (ut) m_tgt[s] = tgt;
            end else if (ut) begin
                m_valid[s] = 1; m_tag[s] = tag_of(pc); m_jump[s] = 0; m_ctr[s] = 2; m_tgt[s] = tgt;
            end
        end
    endtask

    function automatic logic [31:0] rand_pc();
        return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
               | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        rst_n = 1'b0;
        lookup_pc = 32'h100;
        upd_pc = '0;
        upd_target = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Counter walk, alias, miss handling, type-less update, flush-vs-update.
        vecs.push_back(mk(0,0,0,0, 32'h0,   32'h0,   0, 32'h100, 0,0,0,0, 32'h0));
        vecs.push_back(mk(1,0,1,1, 32'h100, 32'h80,  0, 32'h100, 1,0,1,1, 32'h80));
        vecs.push_back(mk(1,0,1,0, 32'h100, 32'h999, 0, 32'h100, 1,0,0,1, 32'h80));
        vecs.push_back(mk(1,0,1,0, 32'h100, 32'h0,   0, 32'h100, 1,0,0,1, 32'h80));
        vecs.push_back(mk(1,0,1,0, 32'h100, 32'h0,   0, 32'h100, 1,0,0,1, 32'h80));
        vecs.push_back(mk(1,0,1,1, 32'h100, 32'h84,  0, 32'h100, 1,0,0,1, 32'h84));
        vecs.push_back(mk(1,0,1,1, 32'h100, 32'h80,  0, 32'h100, 1,0,1,1, 32'h80));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1,0,1,1, 32'h100, 32'h80, 0, 32'h100, 1,0,1,1, 32'h80));
        vecs.push_back(mk(1,0,1,0, 32'h100, 32'h0,   0, 32'h100, 1,0,1,1, 32'h80));
        vecs.push_back(mk(1,0,1,0, 32'h100, 32'h0,   0, 32'h100, 1,0,0,1, 32'h80));
        vecs.push_back(mk(1,1,0,1, 32'h140, 32'h200, 0, 32'h100, 0,0,0,0, 32'h0));
        vecs.push_back(mk(0,0,0,0, 32'h0,   32'h0,   0, 32'h140, 1,1,1,1, 32'h200));
        vecs.push_back(mk(1,0,1,0, 32'h104, 32'h500, 0, 32'h104, 0,0,0,0, 32'h0));
        vecs.push_back(mk(1,0,0,1, 32'h108, 32'h500, 0, 32'h108, 0,0,0,0, 32'h0));
        vecs.push_back(mk(1,0,1,1, 32'h108, 32'h300, 0, 32'h108, 1,0,1,1, 32'h300));
        vecs.push_back(mk(1,1,0,1, 32'h108, 32'h400, 0, 32'h108, 1,1,1,1, 32'h400));
        vecs.push_back(mk(1,0,1,0, 32'h108, 32'h0,   0, 32'h10B, 1,0,1,1, 32'h400));
        vecs.push_back(mk(1,1,0,1, 32'h10C, 32'h700, 1, 32'h10C, 0,0,0,0, 32'h0));
        vecs.push_back(mk(0,0,0,0, 32'h0,   32'h0,   0, 32'h108, 0,0,0,0, 32'h0));
        vecs.push_back(mk(0,0,0,0, 32'h0,   32'h0,   0, 32'h140, 0,0,0,0, 32'h0));

        foreach (vecs[i]) apply_vec(i, vecs[i]);

        // Same-cycle lookup and update on one slot: lookup sees old contents.
        upd_valid = 1; upd_is_jump = 1; upd_pc = 32'h200; upd_target = 32'h500;
        @(posedge clk); #1; idle_inputs();
        lookup_pc = 32'h200;
        upd_valid = 1; upd_is_jump = 1; upd_pc = 32'h240; upd_target = 32'h600;
        #1;
        $display("same-cycle: lookup 200 during update 240 -> hit=%0b tgt=%0h", lookup_hit, lookup_target);
        chk("samecyc pre hit", 32'(lookup_hit), 32'd1);
        chk("samecyc pre target", lookup_target, 32'h500);
        @(posedge clk); #1; idle_inputs();
        #1;
        chk("samecyc old tag evicted", 32'(lookup_hit), 32'd0);
        lookup_pc = 32'h240;
        #1;
        $display("same-cycle: after edge lookup 240 -> hit=%0b tgt=%0h", lookup_hit, lookup_target);
        chk("samecyc new hit", 32'(lookup_hit), 32'd1);
        chk("samecyc new target", lookup_target, 32'h600);

        // Asynchronous reset mid-cycle, with an update held across the reset edge.
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: lookup 240 -> hit=%0b", lookup_hit);
        chk("async reset clears", 32'(lookup_hit), 32'd0);
        upd_valid = 1; upd_is_jump = 1; upd_pc = 32'h300; upd_target = 32'h900;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_inputs();
        lookup_pc = 32'h300;
        #1;
        $display("async reset: in-flight update 300 -> hit=%0b", lookup_hit);
        chk("reset drops update", 32'(lookup_hit), 32'd0);

        // Randomised phase against the reference model (table empty after reset).
        foreach (m_valid[i]) m_valid[i] = 0;
        for (int it = 0; it < 400; it++) begin
            logic [31:0] lpc, upc, utgt;
            bit uv, uj, ub, ut, fl, eh, ej, et;
            int k;
            lpc  = rand_pc();
            upc  = ($urandom_range(0, 1) == 1) ? lpc : rand_pc();
            utgt = $urandom;
            k    = int'($urandom_range(0, 3));
            uv   = (k != 0);
            uj   = (k == 1);
            ub   = (k >= 2);
            ut   = uj ? 1'b1 : bit'($urandom_range(0, 1));
            fl   = ($urandom_range(0, 19) == 0);
            lookup_pc = lpc; upd_valid = uv; upd_is_jump = uj; upd_is_branch = ub;
            upd_taken = ut; upd_pc = upc; upd_target = utgt; flush = fl;
            #1;
            eh = m_hit(lpc);
            ej = eh && m_jump[slot_of(lpc)];
            et = eh && (m_jump[slot_of(lpc)] || m_ctr[slot_of(lpc)] >= 2);
            $display("rnd %0d: lookup %0h hit=%0b/%0b tkn=%0b/%0b | upd v=%0b j=%0b b=%0b t=%0b pc=%0h fl=%0b",
                     it, lpc, lookup_hit, eh, lookup_taken, et, uv, uj, ub, ut, upc, fl);
            chk("rnd hit", 32'(lookup_hit), 32'(eh));
            chk("rnd is_jump", 32'(lookup_is_jump), 32'(ej));
            chk("rnd taken", 32'(lookup_taken), 32'(et));
            if (eh)
                chk("rnd target", lookup_target, m_tgt[slot_of(lpc)]);
            @(posedge clk);
            model_update(fl, uv, uj, ub, ut, upc, utgt);
            #1;
            idle_inputs();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
